// File: rtl/player_motion_pkg.sv
// Shared types for the player motion controller: axis FSM states and signed step direction.
// Optional build macro: PLAYER_MOTION_WRAP_EN (wrapping edges, used by player_motion_ctrl).
package player_motion_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    REPEAT
  } axis_state_e;

  typedef logic signed [1:0] dir_t;

  localparam dir_t DIR_NONE = 2'sb00;
  localparam dir_t DIR_POS  = 2'sb01;
  localparam dir_t DIR_NEG  = 2'sb11;

  localparam int unsigned PLAY_STATE_DEF = 2;

  // Opposing keys held together cancel to no motion.
  function automatic dir_t axis_dir(input logic pos_key, input logic neg_key);
    if (pos_key && !neg_key) begin
      return DIR_POS;
    end else if (neg_key && !pos_key) begin
      return DIR_NEG;
    end
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/player_motion_if.sv
// Button/spawn/state inputs and position/pulse outputs of the player motion controller.
interface player_motion_if #(
  parameter int X_W     = 7,
  parameter int Y_W     = 7,
  parameter int STATE_W = 4
);
  logic [STATE_W-1:0] state;
  logic               up;
  logic               down;
  logic               left;
  logic               right;
  logic               spawn_valid;
  logic [X_W-1:0]     spawn_x;
  logic [Y_W-1:0]     spawn_y;
  logic [X_W-1:0]     pos_x;
  logic [Y_W-1:0]     pos_y;
  logic               moved;
  logic               edge_bump;

  modport master (
    output state, up, down, left, right, spawn_valid, spawn_x, spawn_y,
    input  pos_x, pos_y, moved, edge_bump
  );

  modport slave (
    input  state, up, down, left, right, spawn_valid, spawn_x, spawn_y,
    output pos_x, pos_y, moved, edge_bump
  );
endinterface

// File: rtl/player_motion_ctrl_axis.sv
// One axis of press-then-auto-repeat: immediate step on press, first repeat after
// FIRST_DELAY cycles, then every REPEAT_PERIOD cycles. step_req is combinational.
module motion_axis_repeat
  import player_motion_pkg::*;
#(
  parameter int CNT_W         = 22,
  parameter int FIRST_DELAY   = 3333333,
  parameter int REPEAT_PERIOD = 1666667
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic load,
  input  dir_t dir,
  output logic step_req,
  output dir_t step_dir
);

  localparam logic [CNT_W-1:0] FIRST_LAST  = CNT_W'(FIRST_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

  axis_state_e      st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_t             dir_q, dir_d;

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    step_req = 1'b0;
    if (load) begin
      cnt_d = '0;
      dir_d = dir;
      st_d  = (dir != DIR_NONE) ? FIRST : IDLE;
    end else if (!enable || dir == DIR_NONE) begin
      st_d  = IDLE;
      cnt_d = '0;
      dir_d = DIR_NONE;
    end else if (st_q == IDLE || dir != dir_q) begin
      // Fresh press or reversal both restart the first-delay window.
      step_req = 1'b1;
      st_d     = FIRST;
      cnt_d    = '0;
      dir_d    = dir;
    end else if (st_q == FIRST) begin
      if (cnt_q == FIRST_LAST) begin
        step_req = 1'b1;
        st_d     = REPEAT;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      if (cnt_q == REPEAT_LAST) begin
        step_req = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign step_dir = dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      dir_q <= DIR_NONE;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player (x, y) register owner: auto-repeat stepping, spawn load, edge handling, pulses.
// Define PLAYER_MOTION_WRAP_EN to wrap at the edges instead of saturating.
module player_motion_ctrl
  import player_motion_pkg::*;
#(
  parameter int X_W           = 7,
  parameter int Y_W           = 7,
  parameter int X_MAX         = 79,
  parameter int Y_MAX         = 59,
  parameter int CNT_W         = 22,
  parameter int REPEAT_PERIOD = 1666667,
  parameter int FIRST_DELAY   = 3333333,
  parameter int STATE_W       = 4,
  parameter int PLAY_STATE    = PLAY_STATE_DEF,
  parameter int RESET_X       = 40,
  parameter int RESET_Y       = 30
) (
  input logic            clk,
  input logic            rst_n,
  player_motion_if.slave bus
);

  localparam logic [X_W-1:0] X_MAX_C = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_MAX_C = Y_W'(Y_MAX);

  logic           play;
  dir_t           dir_x, dir_y, sdir_x, sdir_y;
  logic           step_x, step_y;
  logic           bump_x, bump_y;
  logic [X_W-1:0] pos_x_q, pos_x_d;
  logic [Y_W-1:0] pos_y_q, pos_y_d;
  logic           moved_q, moved_d;
  logic           edge_bump_q, edge_bump_d;

  assign play  = (bus.state == STATE_W'(PLAY_STATE));
  assign dir_x = axis_dir(bus.right, bus.left);
  assign dir_y = axis_dir(bus.up, bus.down);

  motion_axis_repeat #(
    .CNT_W        (CNT_W),
    .FIRST_DELAY  (FIRST_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_axis_x (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (play),
    .load    (bus.spawn_valid),
    .dir     (dir_x),
    .step_req(step_x),
    .step_dir(sdir_x)
  );

  motion_axis_repeat #(
    .CNT_W        (CNT_W),
    .FIRST_DELAY  (FIRST_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_axis_y (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (play),
    .load    (bus.spawn_valid),
    .dir     (dir_y),
    .step_req(step_y),
    .step_dir(sdir_y)
  );

  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    bump_x  = 1'b0;
    bump_y  = 1'b0;
    moved_d = 1'b0;
    if (bus.spawn_valid) begin
      pos_x_d = (bus.spawn_x > X_MAX_C) ? X_MAX_C : bus.spawn_x;
      pos_y_d = (bus.spawn_y > Y_MAX_C) ? Y_MAX_C : bus.spawn_y;
    end else begin
      if (step_x) begin
        if (sdir_x == DIR_POS) begin
          if (pos_x_q >= X_MAX_C) begin
`ifdef PLAYER_MOTION_WRAP_EN
            pos_x_d = '0;
`else
            bump_x = 1'b1;
`endif
          end else begin
            pos_x_d = pos_x_q + X_W'(1);
          end
        end else begin
          if (pos_x_q == '0) begin
`ifdef PLAYER_MOTION_WRAP_EN
            pos_x_d = X_MAX_C;
`else
            bump_x = 1'b1;
`endif
          end else begin
            pos_x_d = pos_x_q - X_W'(1);
          end
        end
      end
      if (step_y) begin
        if (sdir_y == DIR_POS) begin
          if (pos_y_q >= Y_MAX_C) begin
`ifdef PLAYER_MOTION_WRAP_EN
            pos_y_d = '0;
`else
            bump_y = 1'b1;
`endif
          end else begin
            pos_y_d = pos_y_q + Y_W'(1);
          end
        end else begin
          if (pos_y_q == '0) begin
`ifdef PLAYER_MOTION_WRAP_EN
            pos_y_d = Y_MAX_C;
`else
            bump_y = 1'b1;
`endif
          end else begin
            pos_y_d = pos_y_q - Y_W'(1);
          end
        end
      end
      moved_d = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
    end
    edge_bump_d = bump_x | bump_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q     <= X_W'(RESET_X);
      pos_y_q     <= Y_W'(RESET_Y);
      moved_q     <= 1'b0;
      edge_bump_q <= 1'b0;
    end else begin
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      moved_q     <= moved_d;
      edge_bump_q <= edge_bump_d;
    end
  end

  assign bus.pos_x     = pos_x_q;
  assign bus.pos_y     = pos_y_q;
  assign bus.moved     = moved_q;
  assign bus.edge_bump = edge_bump_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl with short delays and a 6x4 playfield.
module tb_player_motion_ctrl;

  localparam int X_W = 4;
  localparam int Y_W = 3;
  localparam int STATE_W = 4;

  typedef struct {
    logic [3:0] st;
    logic       u, d, l, r, sv;
    int         sx, sy;
    int         ex, ey, em, eb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  player_motion_if #(.X_W(X_W), .Y_W(Y_W), .STATE_W(STATE_W)) bus ();

  player_motion_ctrl #(
    .X_W          (X_W),
    .Y_W          (Y_W),
    .X_MAX        (5),
    .Y_MAX        (3),
    .CNT_W        (4),
    .REPEAT_PERIOD(4),
    .FIRST_DELAY  (8),
    .STATE_W      (STATE_W),
    .PLAY_STATE   (2),
    .RESET_X      (2),
    .RESET_Y      (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic vec_t mk(input int st, input logic u, d, l, r, sv, input int sx, sy,
                              input int ex, ey, em, eb);
    vec_t v;
    v.st = 4'(st); v.u = u; v.d = d; v.l = l; v.r = r; v.sv = sv;
    v.sx = sx; v.sy = sy; v.ex = ex; v.ey = ey; v.em = em; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int ex, ey, em, eb);
    chk({tag, "_x"}, int'(bus.pos_x), ex);
    chk({tag, "_y"}, int'(bus.pos_y), ey);
    chk({tag, "_moved"}, int'(bus.moved), em);
    chk({tag, "_bump"}, int'(bus.edge_bump), eb);
  endtask

  task automatic drive(input int st, input logic u, d, l, r);
    bus.state = 4'(st);
    bus.up = u; bus.down = d; bus.left = l; bus.right = r;
    bus.spawn_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(2, 0, 0, 0, 0);
    bus.spawn_x = '0;
    bus.spawn_y = '0;
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int npulse;
    int ex, em, eb;

    // Diagonal hold to the corner, then spawn back and test L+R cancellation.
    vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 0, 3, 2, 1, 0));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 0, 3, 2, 0, 0));
    vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 0, 4, 3, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 0, 4, 3, 0, 0));
    vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 0, 5, 3, 1, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 0, 5, 3, 0, 0));
    vecs.push_back(mk(2, 1, 0, 0, 1, 0, 0, 0, 5, 3, 0, 1));
    vecs.push_back(mk(2, 0, 0, 0, 0, 1, 2, 1, 2, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(2, 0, 0, 1, 1, 0, 0, 0, 2, 1, 0, 0));
    vecs.push_back(mk(2, 0, 0, 0, 1, 0, 0, 0, 3, 1, 1, 0));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));

    do_reset();
    #1;
    check_out("reset", 2, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(int'(vecs[i].st), vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r);
      bus.spawn_valid = vecs[i].sv;
      bus.spawn_x = X_W'(vecs[i].sx);
      bus.spawn_y = Y_W'(vecs[i].sy);
      tick();
      check_out($sformatf("tbl%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].em, vecs[i].eb);
    end

    // Hold right 21 cycles: steps at 0, 8, 12; blocked at 16 and 20.
    do_reset();
    drive(2, 0, 0, 0, 1);
    npulse = 0;
    for (int c = 0; c <= 20; c++) begin
      tick();
      ex = (c < 8) ? 3 : (c < 12) ? 4 : 5;
      em = (c == 0 || c == 8 || c == 12) ? 1 : 0;
      eb = (c == 16 || c == 20) ? 1 : 0;
      if (bus.moved) npulse++;
      check_out($sformatf("hold_r%0d", c), ex, 1, em, eb);
    end
    chk("hold_r_pulses", npulse, 3);

    // Reversal at cycle 5 restarts the first delay.
    do_reset();
    drive(2, 0, 0, 0, 1);
    for (int c = 0; c <= 13; c++) begin
      if (c == 5) drive(2, 0, 0, 1, 0);
      tick();
      ex = (c < 5) ? 3 : (c < 13) ? 2 : 1;
      em = (c == 0 || c == 5 || c == 13) ? 1 : 0;
      check_out($sformatf("rev%0d", c), ex, 1, em, 0);
    end

    // Spawn with clamp while right is held; next step is the first-delay one and blocked.
    do_reset();
    drive(2, 0, 0, 0, 1);
    tick();
    check_out("sp_press", 3, 1, 1, 0);
    bus.spawn_valid = 1'b1;
    bus.spawn_x = 4'd9;
    bus.spawn_y = 3'd0;
    tick();
    check_out("sp_load", 5, 0, 0, 0);
    bus.spawn_valid = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      tick();
      check_out($sformatf("sp%0d", c), 5, 0, 0, (c == 9) ? 1 : 0);
    end

    // Down held at y=0 across a trip out of play; re-entry steps immediately.
    do_reset();
    drive(2, 0, 1, 0, 0);
    bus.spawn_valid = 1'b1;
    bus.spawn_x = 4'd2;
    bus.spawn_y = 3'd0;
    tick();
    check_out("gate_load", 2, 0, 0, 0);
    bus.spawn_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 3) bus.state = 4'd3;
      tick();
      check_out($sformatf("gate%0d", c), 2, 0, 0, 0);
    end
    bus.state = 4'd2;
    tick();
`ifdef PLAYER_MOTION_WRAP_EN
    check_out("gate_reentry", 2, 3, 1, 0);
`else
    check_out("gate_reentry", 2, 0, 0, 1);
`endif

    // Asynchronous reset mid-hold returns to reset values without a clock edge.
    do_reset();
    drive(2, 0, 0, 0, 1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 2, 1, 0, 0);
    do_reset();
    tick();
    check_out("post_rst", 2, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
